rr_grant_scheduler: RTL and testbench
=====================================

RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 4, maximum consecutive cycles a requester may hold a grant (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester request, level-sensitive.
REQ-006 SHALL have port en  input  NREQ  per-requester enable; en[i]=0 masks req[i].
REQ-007 SHALL have port grant  output  NREQ  registered grant, one-hot or all-zero.
REQ-008 SHALL have port grant_id  output  $clog2(NREQ)  index of current holder; 0 when busy=0.
REQ-009 SHALL have port busy  output  1  high exactly when grant != 0.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse flagging a forced release.

Function
REQ-011 SHALL define eligible[i] = req[i] & en[i].
REQ-012 SHALL implement FSM states IDLE, GRANT, GAP; grant != 0 only in GRANT.
REQ-013 IDLE: if any eligible, SHALL go to GRANT next cycle with grant set to the winner; else remain IDLE.
REQ-014 Winner SHALL be the first eligible index at or after rotating pointer ptr, searching upward modulo NREQ.
REQ-015 Latency from eligible request (sampled at posedge N) to grant high SHALL be one cycle (visible after posedge N).
REQ-016 GRANT: hold counter hcnt SHALL be 1 on the first grant cycle and increment each further GRANT cycle.
REQ-017 GRANT SHALL go to GAP when eligible[holder]=0, or when hcnt = MAX_HOLD with eligible[holder] still 1 (forced release).
REQ-018 GRANT SHALL NOT change holder while in GRANT; other requests are ignored until GAP.
REQ-019 On leaving GRANT, ptr SHALL become (holder+1) mod NREQ; ptr wraps from NREQ-1 to 0.
REQ-020 GAP SHALL last exactly one cycle with grant=0; then GRANT if any eligible (arbitrated per REQ-014 with the updated ptr), else IDLE.
REQ-021 timeout SHALL be 1 during the GAP cycle that follows a forced release, 0 otherwise.
REQ-022 Simultaneous drop of eligible[holder] and hcnt = MAX_HOLD SHALL count as voluntary release (timeout=0).
REQ-023 MAX_HOLD=1 SHALL yield single-cycle grants, each followed by GAP, with timeout=1 if the holder still requested.
REQ-024 grant, grant_id, busy, timeout SHALL all be driven from flops (no combinational input-to-output path).

Reset
REQ-025 reset=1 SHALL immediately force state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, ptr=0, hcnt=0, independent of clk.
REQ-026 Reset asserted mid-grant SHALL drop grant without a GAP cycle or timeout pulse; first posedge after deassertion behaves as IDLE.

Structure
REQ-027 Package arb_pkg SHALL hold the FSM state enum typedef (IDLE, GRANT, GAP) and the NREQ default constant.
REQ-028 Rotating-priority selection SHALL be a combinational sub-module rr_pick (inputs eligible, ptr; outputs valid, index).
REQ-029 Top module SHALL contain only the FSM, ptr, hcnt and output registers.

Verification (NREQ=3, MAX_HOLD=4)
REQ-030 Reset then req=001, en=111 held -> grant=001 one cycle after first sample, held 4 cycles, GAP with timeout=1, regrant 001, ptr=1.
REQ-031 req=111, en=111 held from reset -> grants cycle 001,010,100,001 (4 cycles each, 1-cycle zero gap between, timeout=1 in each gap).
REQ-032 req=110, en=101 -> only requester 2 granted; req[1] never granted; grant_id=2, busy=1.
REQ-033 Requester 0 granted, req[0] drops after 2 grant cycles while req[2]=1 -> GAP, timeout=0, then grant=100.
REQ-034 reset pulsed in the 3rd grant cycle of requester 1 -> grant=000 immediately, no timeout; after release with req=011, grant=001 (ptr=0).
REQ-035 Every cycle: grant one-hot or zero, busy == |grant, grant_id matches grant; any violation counts as an error.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state encoding and default requester count for the round-robin scheduler
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam int NREQ_DEF = 3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority pick of the first eligible index at or above ptr
import arb_pkg::*;
module rr_pick #(
  parameter int N = NREQ_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] index
);
  assign valid = |eligible;
  // Scan from the farthest offset down so the closest eligible index wins last.
  always_comb begin
    index = '0;
    for (int k = N - 1; k >= 0; k--)
      if (eligible[(int'(ptr) + k) % N]) index = W'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin grant FSM with bounded hold time, one-cycle gap and forced-release flag
import arb_pkg::*;
module rr_grant_scheduler #(
  parameter int NREQ     = NREQ_DEF,
  parameter int MAX_HOLD = 4,
  localparam int W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] en,
  output logic [NREQ-1:0] grant,
  output logic [W-1:0]    grant_id,
  output logic            busy,
  output logic            timeout
);
  state_t state, state_n;
  logic [NREQ-1:0] eligible, grant_n;
  logic [W-1:0] ptr, ptr_n, pick_idx, grant_id_n;
  logic [7:0] hcnt, hcnt_n;
  logic pick_valid, busy_n, timeout_n, held, expired;
  assign eligible = req & en;
  assign held = eligible[grant_id];
  assign expired = hcnt == 8'(MAX_HOLD);
  rr_pick #(.N(NREQ)) u_pick (
    .eligible(eligible),
    .ptr(ptr),
    .valid(pick_valid),
    .index(pick_idx)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      hcnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_id <= grant_id_n;
      busy <= busy_n;
      timeout <= timeout_n;
      ptr <= ptr_n;
      hcnt <= hcnt_n;
    end
  end
  always_comb
    state_n = state == GRANT ? ((!held || expired) ? GAP : GRANT) : (pick_valid ? GRANT : IDLE);
  // A release with the holder still eligible can only be the hold limit expiring.
  always_comb begin
    grant_n = '0;
    grant_id_n = '0;
    busy_n = 1'b0;
    timeout_n = 1'b0;
    hcnt_n = '0;
    ptr_n = ptr;
    if (state == GRANT && state_n == GRANT) begin
      grant_n = grant;
      grant_id_n = grant_id;
      busy_n = 1'b1;
      hcnt_n = hcnt + 8'd1;
    end else if (state == GRANT) begin
      ptr_n = grant_id == W'(NREQ - 1) ? '0 : grant_id + W'(1);
      timeout_n = held;
    end else if (state_n == GRANT) begin
      grant_n = NREQ'(1) << pick_idx;
      grant_id_n = pick_idx;
      busy_n = 1'b1;
      hcnt_n = 8'd1;
    end
  end
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: directed scoreboard bench for rr_grant_scheduler with NREQ=3, MAX_HOLD=4
module tb_rr_grant_scheduler;
  typedef struct {logic [2:0] g; logic t;} exp_t;
  logic clk, reset;
  logic [2:0] req, en, grant;
  logic [1:0] grant_id;
  logic busy, timeout;
  int tests = 0, fails = 0;
  exp_t sb[$];
  rr_grant_scheduler #(.NREQ(3), .MAX_HOLD(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .en(en),
    .grant(grant),
    .grant_id(grant_id),
    .busy(busy),
    .timeout(timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [1:0] idx_of(input logic [2:0] g);
    idx_of = 2'd0;
    for (int i = 0; i < 3; i++) if (g[i]) idx_of = 2'(i);
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [2:0] r, input logic [2:0] e, input logic [2:0] g, input logic t);
    exp_t x;
    req = r;
    en = e;
    sb.push_back('{g, t});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("grant", 8'(grant), 8'(x.g));
    chk("timeout", 8'(timeout), 8'(x.t));
    chk("busy", 8'(busy), 8'(|x.g));
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    en = '0;
    #1;
    chk("rst_grant", 8'(grant), 8'h0);
    chk("rst_id", 8'(grant_id), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_timeout", 8'(timeout), 8'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  always @(negedge clk)
    if (!reset) begin
      tests++;
      assert ($onehot0(grant) && busy === |grant && grant_id === idx_of(grant)) else begin
        fails++;
        $error("FAIL invariant observed grant=%b busy=%b id=%0d expected consistent", grant, busy, grant_id);
      end
    end
  initial begin
    reset = 1'b1;
    req = '0;
    en = '0;
    // single requester: hold limit, forced gap, regrant after pointer moves past it
    do_reset;
    repeat (4) step(3'b001, 3'b111, 3'b001, 1'b0);
    step(3'b001, 3'b111, 3'b000, 1'b1);
    repeat (4) step(3'b001, 3'b111, 3'b001, 1'b0);
    step(3'b001, 3'b111, 3'b000, 1'b1);
    // all requesting: full rotation including pointer wrap
    do_reset;
    for (int k = 0; k < 4; k++) begin
      repeat (4) step(3'b111, 3'b111, k == 3 ? 3'b001 : 3'(1 << k), 1'b0);
      step(3'b111, 3'b111, 3'b000, 1'b1);
    end
    // enable mask hides requester 1
    do_reset;
    repeat (4) step(3'b110, 3'b101, 3'b100, 1'b0);
    chk("mask_id", 8'(grant_id), 8'd2);
    step(3'b110, 3'b101, 3'b000, 1'b1);
    step(3'b110, 3'b101, 3'b100, 1'b0);
    // voluntary release hands over to requester 2 with no timeout
    do_reset;
    repeat (2) step(3'b101, 3'b111, 3'b001, 1'b0);
    step(3'b100, 3'b111, 3'b000, 1'b0);
    step(3'b100, 3'b111, 3'b100, 1'b0);
    // async reset mid-grant of requester 1 clears outputs and pointer
    do_reset;
    step(3'b001, 3'b111, 3'b001, 1'b0);
    step(3'b010, 3'b111, 3'b000, 1'b0);
    repeat (3) step(3'b010, 3'b111, 3'b010, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_grant", 8'(grant), 8'h0);
    chk("midrst_timeout", 8'(timeout), 8'h0);
    chk("midrst_busy", 8'(busy), 8'h0);
    chk("midrst_id", 8'(grant_id), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    step(3'b011, 3'b111, 3'b001, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
